// File: rtl/sd_fifo_wm.sv
// Parametrised SD data-path FIFO with watermarks, peak-occupancy monitor and sticky error flags.
// Define SD_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one cycle of latency.
module sd_fifo_wm #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8,
  localparam int CW = DEPTH_LOG2 + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fifo_flush,
  input  logic                  i_fifo_push,
  input  logic                  i_fifo_pop,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic [CW-1:0]         i_fifo_af_level,
  input  logic [CW-1:0]         i_fifo_ae_level,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  output logic [CW-1:0]         o_fifo_items,
  output logic [CW-1:0]         o_fifo_peak,
  output logic                  o_fifo_empty,
  output logic                  o_fifo_full,
  output logic                  o_fifo_almost_empty,
  output logic                  o_fifo_almost_full,
  output logic                  o_fifo_overrun,
  output logic                  o_fifo_underrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         items_q, items_d;
  logic [CW-1:0]         peak_q, peak_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic                  empty, full, push_ok, pop_ok, wr_en;

  assign empty   = (items_q == '0);
  assign full    = (items_q == DEPTH_C);
  assign pop_ok  = i_fifo_pop && !empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign push_ok = i_fifo_push && (!full || pop_ok);
  assign wr_en   = push_ok && !i_fifo_flush && !i_reset;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    items_d    = items_q;
    peak_d     = peak_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (i_fifo_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      items_d    = '0;
      peak_d     = '0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      items_d = items_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop_ok};
      if (items_d > peak_q) peak_d = items_d;
      if (i_fifo_push && !push_ok) overrun_d = 1'b1;
      if (i_fifo_pop && !pop_ok)   underrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      items_q    <= '0;
      peak_q     <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      items_q    <= items_d;
      peak_q     <= peak_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage array carries no reset so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q] <= i_fifo_data;
  end

`ifdef SD_FIFO_FWFT_EN
  assign o_fifo_data = mem[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Flush discards a same-cycle pop, so the held word survives it.
  always_comb begin
    rdata_d = rdata_q;
    if (pop_ok && !i_fifo_flush) rdata_d = mem[rd_ptr_q];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign o_fifo_data = rdata_q;
`endif

  assign o_fifo_items        = items_q;
  assign o_fifo_peak         = peak_q;
  assign o_fifo_empty        = empty;
  assign o_fifo_full         = full;
  assign o_fifo_almost_empty = (items_q <= i_fifo_ae_level);
  assign o_fifo_almost_full  = (items_q >= i_fifo_af_level);
  assign o_fifo_overrun      = overrun_q;
  assign o_fifo_underrun     = underrun_q;

endmodule

// File: tb/tb_sd_fifo_wm.sv
// Directed self-checking bench for sd_fifo_wm (default build, registered read data).
// A queue holds the expected contents; popped words and all status outputs are checked every cycle.
module tb_sd_fifo_wm;

  localparam int DW = 32;
  localparam int DL = 8;
  localparam int CW = DL + 1;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, push, pop;
  logic [DW-1:0] wdata;
  logic [CW-1:0] af_level, ae_level;
  logic [DW-1:0] rdata;
  logic [CW-1:0] items, peak;
  logic          empty, full, aempty, afull, overrun, underrun;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb[$];
  int            mdl_peak;
  logic          mdl_ovr, mdl_und;
  logic [DW-1:0] mdl_data;

  sd_fifo_wm #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_fifo_flush        (flush),
    .i_fifo_push         (push),
    .i_fifo_pop          (pop),
    .i_fifo_data         (wdata),
    .i_fifo_af_level     (af_level),
    .i_fifo_ae_level     (ae_level),
    .o_fifo_data         (rdata),
    .o_fifo_items        (items),
    .o_fifo_peak         (peak),
    .o_fifo_empty        (empty),
    .o_fifo_full         (full),
    .o_fifo_almost_empty (aempty),
    .o_fifo_almost_full  (afull),
    .o_fifo_overrun      (overrun),
    .o_fifo_underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every status output against the queue-based model.
  task automatic check_status();
    int n;
    n = sb.size();
    check_output("items", 64'(items), 64'(n));
    check_output("peak", 64'(peak), 64'(mdl_peak));
    check_output("empty", 64'(empty), 64'(n == 0));
    check_output("full", 64'(full), 64'(n == DEPTH));
    check_output("almost_empty", 64'(aempty), 64'(n <= int'(ae_level)));
    check_output("almost_full", 64'(afull), 64'(n >= int'(af_level)));
    check_output("overrun", 64'(overrun), 64'(mdl_ovr));
    check_output("underrun", 64'(underrun), 64'(mdl_und));
    check_output("rdata", 64'(rdata), 64'(mdl_data));
  endtask

  // One clock with the given controls; inputs change 1 time unit after the edge.
  task automatic apply_stimulus(input logic f, input logic pu, input logic po, input logic [DW-1:0] d);
    logic pop_ok, push_ok;
    pop_ok  = po && (sb.size() > 0);
    push_ok = pu && ((sb.size() < DEPTH) || pop_ok);
    flush = f; push = pu; pop = po; wdata = d;
    @(posedge clk);
    #1;
    flush = 1'b0; push = 1'b0; pop = 1'b0;
    if (f) begin
      sb.delete();
      mdl_peak = 0;
      mdl_ovr  = 1'b0;
      mdl_und  = 1'b0;
    end else begin
      if (pop_ok) mdl_data = sb.pop_front();
      if (push_ok) sb.push_back(d);
      if (pu && !push_ok) mdl_ovr = 1'b1;
      if (po && !pop_ok)  mdl_und = 1'b1;
      if (sb.size() > mdl_peak) mdl_peak = sb.size();
    end
    check_status();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;
    af_level = 9'd192; ae_level = 9'd16;
    mdl_peak = 0; mdl_ovr = 1'b0; mdl_und = 1'b0; mdl_data = '0;
    repeat (3) @(posedge clk);
    #3;
    check_status();
    af_level = 9'd0;
    #1;
    check_output("af_at_level0", 64'(afull), 64'd1);
    af_level = 9'd192;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single push and pop");
    apply_stimulus(0, 1, 0, 32'hA5A5_0001);
    check_output("single_peak", 64'(peak), 64'd1);
    apply_stimulus(0, 0, 1, '0);
    check_output("single_data", 64'(rdata), 64'hA5A5_0001);

    $display("[TB] fill to full, overrun, drain");
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(0, 1, 0, DW'(i));
      if (i == 190) check_output("af_191", 64'(afull), 64'd0);
      if (i == 191) check_output("af_192", 64'(afull), 64'd1);
    end
    check_output("full_items", 64'(items), 64'd256);
    apply_stimulus(0, 1, 0, 32'hDEAD_BEEF);
    check_output("overrun_set", 64'(overrun), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(0, 0, 1, '0);
      check_output("drain_word", 64'(rdata), 64'(i));
      if (i == 238) check_output("ae_17", 64'(aempty), 64'd0);
      if (i == 239) check_output("ae_16", 64'(aempty), 64'd1);
    end
    check_output("drained_empty", 64'(empty), 64'd1);
    apply_stimulus(1, 0, 0, '0);

    $display("[TB] wrap-around");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 200; i++) apply_stimulus(0, 1, 0, $urandom);
      for (int i = 0; i < 200; i++) apply_stimulus(0, 0, 1, '0);
    end
    check_output("wrap_peak", 64'(peak), 64'd200);

    $display("[TB] simultaneous push/pop");
    apply_stimulus(0, 1, 1, 32'h1234_5678);
    check_output("sim_empty_und", 64'(underrun), 64'd1);
    apply_stimulus(0, 0, 1, '0);
    apply_stimulus(1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 1, 0, 32'h0100_0000 + DW'(i));
    apply_stimulus(0, 1, 1, 32'hCAFE_0000);
    check_output("sim_full_items", 64'(items), 64'd256);
    check_output("sim_full_ovr", 64'(overrun), 64'd0);
    check_output("sim_full_head", 64'(rdata), 64'h0100_0000);

    $display("[TB] flush with push and pop");
    apply_stimulus(0, 1, 0, 32'hFFFF_0000);
    for (int i = 0; i < 156; i++) apply_stimulus(0, 0, 1, '0);
    check_output("pre_flush_items", 64'(items), 64'd100);
    check_output("pre_flush_ovr", 64'(overrun), 64'd1);
    apply_stimulus(1, 1, 1, 32'hBAD0_BAD0);
    check_output("flush_items", 64'(items), 64'd0);
    check_output("flush_peak", 64'(peak), 64'd0);
    apply_stimulus(0, 1, 0, 32'h600D_0001);
    apply_stimulus(0, 0, 1, '0);
    check_output("post_flush_word", 64'(rdata), 64'h600D_0001);

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, DW'(i + 7));
    #2;
    rst = 1'b1;
    #1;
    sb.delete(); mdl_peak = 0; mdl_ovr = 1'b0; mdl_und = 1'b0; mdl_data = '0;
    check_status();
    @(posedge clk);
    #2;
    rst = 1'b0;
    apply_stimulus(0, 0, 1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
